// File: rtl/de1_seg_decoder.sv
// Registered hex-to-7-segment decoder for the DE1 display.
// Code bits arrive as {Z,Y,W,X}; segments A..G are active-high and blank during reset.
module de1_seg_decoder (
  input  logic clk,
  input  logic rst,
  input  logic W,
  input  logic X,
  input  logic Y,
  input  logic Z,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);

  logic [3:0] code;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign code = {Z, Y, W, X};

  // Segment order is {A,B,C,D,E,F,G}; every code maps to a glyph.
  always_comb begin
    seg_d = 7'b0000000;
    unique case (code)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'ha: seg_d = 7'b1110111;
      4'hb: seg_d = 7'b0011111;
      4'hc: seg_d = 7'b1001110;
      4'hd: seg_d = 7'b0111101;
      4'he: seg_d = 7'b1001111;
      4'hf: seg_d = 7'b1000111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'b0000000;
    end else begin
      seg_q <= seg_d;
    end
  end

  // Outputs come straight from flops so they cannot glitch between edges.
  assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_de1_seg_decoder.sv
// Self-checking bench for de1_seg_decoder: expected glyphs are queued when a code is
// driven and popped when the registered outputs are sampled after the next edge.
module tb_de1_seg_decoder;

  logic clk;
  logic rst;
  logic W, X, Y, Z;
  logic A, B, C, D, E, F, G;

  int unsigned checks;
  int unsigned failures;
  logic [6:0] exp_q[$];

  de1_seg_decoder dut (
    .clk(clk),
    .rst(rst),
    .W  (W),
    .X  (X),
    .Y  (Y),
    .Z  (Z),
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .E  (E),
    .F  (F),
    .G  (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference glyph table, ABCDEFG order.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'ha: glyph = 7'b1110111;
      4'hb: glyph = 7'b0011111;
      4'hc: glyph = 7'b1001110;
      4'hd: glyph = 7'b0111101;
      4'he: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] segs();
    segs = {A, B, C, D, E, F, G};
  endfunction

  task automatic set_code(input logic [3:0] n);
    {Z, Y, W, X} = n;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1;
    set_code(4'h0);
    #2;
    got = segs();
    checks++;
    if (got !== 7'b0000000) begin
      failures++;
      $display("FAIL reset_before_edge: got %b required %b", got, 7'b0000000);
    end
    @(posedge clk);
    #1;
    got = segs();
    checks++;
    if (got !== 7'b0000000) begin
      failures++;
      $display("FAIL reset_over_edge: got %b required %b", got, 7'b0000000);
    end
  endtask

  task automatic test_first_edge();
    logic [6:0] got;
    logic [6:0] exp;
    @(negedge clk);
    rst = 1'b0;
    set_code(4'h0);
    exp_q.push_back(glyph(4'h0));
    @(posedge clk);
    #1;
    got = segs();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL first_edge: got %b required %b", got, exp);
    end
  endtask

  task automatic test_single_codes();
    logic [6:0] got;
    logic [6:0] exp;
    logic [3:0] codes[2];
    codes[0] = 4'h1;
    codes[1] = 4'h2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_code(codes[i]);
      exp_q.push_back(glyph(codes[i]));
      @(posedge clk);
      #1;
      got = segs();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_code_%0d: got %b required %b", codes[i], got, exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [6:0] got;
    logic [6:0] exp;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      set_code(4'(n));
      exp_q.push_back(glyph(4'(n)));
      @(posedge clk);
      #1;
      got = segs();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL sweep_code_%0d: got %b required %b", n, got, exp);
      end
    end
  endtask

  task automatic test_mid_cycle_hold();
    logic [6:0] got;
    logic [6:0] exp;
    @(negedge clk);
    set_code(4'h0);
    exp_q.push_back(glyph(4'h0));
    @(posedge clk);
    #1;
    got = segs();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hold_load: got %b required %b", got, exp);
    end
    @(negedge clk);
    set_code(4'h1);
    exp_q.push_back(glyph(4'h1));
    #2;
    got = segs();
    checks++;
    if (got !== 7'b1111110) begin
      failures++;
      $display("FAIL hold_between_edges: got %b required %b", got, 7'b1111110);
    end
    @(posedge clk);
    #1;
    got = segs();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hold_next_edge: got %b required %b", got, exp);
    end
  endtask

  task automatic test_reset_pulse();
    logic [6:0] got;
    logic [6:0] exp;
    @(negedge clk);
    set_code(4'h8);
    exp_q.push_back(glyph(4'h8));
    @(posedge clk);
    #1;
    got = segs();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL pulse_show_8: got %b required %b", got, exp);
    end
    #1;
    rst = 1'b1;
    #1;
    got = segs();
    checks++;
    if (got !== 7'b0000000) begin
      failures++;
      $display("FAIL pulse_async_blank: got %b required %b", got, 7'b0000000);
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(glyph(4'h8));
    #1;
    got = segs();
    checks++;
    if (got !== 7'b0000000) begin
      failures++;
      $display("FAIL pulse_blank_until_edge: got %b required %b", got, 7'b0000000);
    end
    @(posedge clk);
    #1;
    got = segs();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL pulse_restore: got %b required %b", got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_code(4'h0);
    test_reset();
    test_first_edge();
    test_single_codes();
    test_sweep();
    test_mid_cycle_hold();
    test_reset_pulse();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
